// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 CPU: opcodes, sequencer states and the fixed program image.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned NUM_T_STATES = 6;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstate_e;

  // Program: A = 0xF0 + 0x20 - 0x30 = 0xE0 (mod 256), then OUT and HLT.
  function automatic logic [7:0] prog_image(input logic [3:0] addr);
    logic [7:0] data;
    unique case (addr)
      4'h0:    data = 8'h09;
      4'h1:    data = 8'h1A;
      4'h2:    data = 8'h2B;
      4'h3:    data = 8'hE0;
      4'h4:    data = 8'hF0;
      4'h9:    data = 8'hF0;
      4'hA:    data = 8'h20;
      4'hB:    data = 8'h30;
      default: data = 8'h00;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/sap1_alu.sv
// Combinational 8-bit adder/subtractor; results wrap mod 256 with no flags.
module sap1_alu
  import sap1_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_sub,
  output logic [7:0] o_result
);

  always_comb begin
    o_result = i_sub ? (i_a - i_b) : (i_a + i_b);
  end

endmodule

// File: rtl/sap1_cpu.sv
// SAP-1 CPU tile top: 6-T-state sequencer, 16x8 RAM loaded on reset, A/B/OUT registers.
module sap1_cpu
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] r_pc;
  logic [3:0] r_mar;
  logic [7:0] r_ir;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_out;
  logic       r_halted;
  tstate_e    r_t;
  logic [7:0] r_ram [16];

  logic [7:0] w_ram_data;
  logic [3:0] w_opcode;
  logic [7:0] w_alu_result;
  logic       w_unused;

  assign w_ram_data = r_ram[r_mar];
  assign w_opcode   = r_ir[7:4];
  // Tile inputs carry no function in this design.
  assign w_unused   = &{1'b0, ena, ui_in, uio_in};

  sap1_alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_sub    (w_opcode == OP_SUB),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= 4'h0;
      r_mar    <= 4'h0;
      r_ir     <= 8'h00;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_out    <= 8'h00;
      r_halted <= 1'b0;
      r_t      <= T0;
      for (int i = 0; i < 16; i++) begin
        r_ram[i] <= prog_image(4'(i));
      end
    end else if (!r_halted) begin
      unique case (r_t)
        T0: begin
          r_mar <= r_pc;
          r_t   <= T1;
        end
        T1: begin
          r_pc <= r_pc + 4'd1;
          r_t  <= T2;
        end
        T2: begin
          r_ir <= w_ram_data;
          r_t  <= T3;
        end
        T3: begin
          unique case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB: r_mar    <= r_ir[3:0];
            OP_OUT:                 r_out    <= r_a;
            OP_HLT:                 r_halted <= 1'b1;
            default: ;
          endcase
          r_t <= T4;
        end
        T4: begin
          unique case (w_opcode)
            OP_LDA:         r_a <= w_ram_data;
            OP_ADD, OP_SUB: r_b <= w_ram_data;
            default: ;
          endcase
          r_t <= T5;
        end
        T5: begin
          if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
            r_a <= w_alu_result;
          end
          r_t <= T0;
        end
        default: r_t <= T0;
      endcase
    end
  end

  assign uo_out  = r_out;
  assign uio_out = {r_pc, r_halted, r_t};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_sap1_cpu.sv
// Directed bench for sap1_cpu: reset, fetch timing, full program, halt and re-reset.
module tb_sap1_cpu;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  sap1_cpu dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected uio_out after edge e counted from reset release (e=0: still in reset state).
  function automatic logic [7:0] exp_uio(input int e);
    int j, k, pc, t;
    if (e == 0) return 8'h00;
    if (e >= 28) return 8'h5C;
    j  = (e - 1) % 6;
    k  = (e - 1) / 6;
    pc = (j >= 1) ? k + 1 : k;
    t  = e % 6;
    return {4'(pc), 1'b0, 3'(t)};
  endfunction

  function automatic logic [7:0] exp_uo(input int e);
    return (e >= 22) ? 8'hE0 : 8'h00;
  endfunction

  task automatic run_edges(input int from_e, input int to_e, input string tag);
    for (int e = from_e; e <= to_e; e++) begin
      step();
      check_val($sformatf("%s uio_out e%0d", tag, e), uio_out, exp_uio(e));
      check_val($sformatf("%s uo_out e%0d", tag, e), uo_out, exp_uo(e));
    end
  endtask

  initial begin
    ena    = 1'b1;
    ui_in  = 8'hxx;
    uio_in = 8'hzz;
    rst    = 1'b1;

    repeat (5) step();
    check_val("reset uo_out", uo_out, 8'h00);
    check_val("reset uio_out", uio_out, 8'h00);
    check_val("reset uio_oe", uio_oe, 8'hFF);
    check_val("reset ram9", dut.r_ram[9], 8'hF0);

    // Fetch timing and full program from first release.
    rst = 1'b0;
    step();
    check_val("fetch e1 uio_out", uio_out, 8'h01);
    step();
    check_val("fetch e2 uio_out", uio_out, 8'h12);
    step();
    check_val("fetch e3 uio_out", uio_out, 8'h13);
    check_val("fetch e3 ir", dut.r_ir, 8'h09);
    run_edges(4, 40, "prog");
    check_val("after-halt a", dut.r_a, 8'hE0);
    check_val("after-halt b", dut.r_b, 8'h30);

    // Halt freeze with floating inputs.
    for (int i = 0; i < 50; i++) begin
      ui_in  = (i % 2 == 0) ? 8'hxx : 8'h5A;
      uio_in = (i % 2 == 0) ? 8'hzz : 8'hA5;
      step();
      check_val($sformatf("halt hold uio_out %0d", i), uio_out, 8'h5C);
      check_val($sformatf("halt hold uo_out %0d", i), uo_out, 8'hE0);
    end

    // Reset from halt, then full rerun.
    rst = 1'b1;
    step();
    check_val("rst-halt uio_out", uio_out, 8'h00);
    check_val("rst-halt uo_out", uo_out, 8'h00);
    rst = 1'b0;
    run_edges(1, 22, "rerun");

    // Reset mid-operation at edge 15 (instruction 2, T2).
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_edges(1, 14, "pre-mid");
    check_val("pre-mid a", dut.r_a, 8'h10);
    rst = 1'b1;
    step();
    check_val("mid-rst uio_out", uio_out, 8'h00);
    check_val("mid-rst uo_out", uo_out, 8'h00);
    check_val("mid-rst a", dut.r_a, 8'h00);
    check_val("mid-rst b", dut.r_b, 8'h00);
    check_val("mid-rst ir", dut.r_ir, 8'h00);
    check_val("mid-rst mar", {4'h0, dut.r_mar}, 8'h00);
    rst = 1'b0;
    run_edges(1, 30, "post-mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sap1_cpu.md
Name: sap1_cpu

Overview:
- 8-bit SAP-1 (Simple-As-Possible) CPU packaged as a TinyTapeout user tile.
- Contains a 4-bit program counter, a 16x8 RAM preloaded with a fixed program on reset, A/B registers, an add/subtract ALU, an output register and a 6-T-state control sequencer.
- The output register drives uo_out; debug status drives uio_out. Top-level block of the tile.

Parameters:
- none (program image is fixed constants in the package)

Ports:
- clk      in   1  system clock, rising edge; all state on this edge
- rst      in   1  synchronous, active-high reset
- ena      in   1  tile enable; ignored by the logic
- ui_in    in   8  unused; must tolerate X/Z without affecting state
- uio_in   in   8  unused; must tolerate X/Z without affecting state
- uo_out   out  8  output register (OUT result)
- uio_out  out  8  [7:4]=PC, [3]=halted, [2:0]=T-state index 0..5
- uio_oe   out  8  constant 8'hFF

Behaviour:
- Reset (rst=1 at a rising edge):
  - PC=0, MAR=0, IR=0, A=0, B=0, OUT=0, halted=0, T=0.
  - RAM loaded with the program image: 0:0x09 LDA 9; 1:0x1A ADD A; 2:0x2B SUB B; 3:0xE0 OUT; 4:0xF0 HLT; 5-8:0x00; 9:0xF0; A:0x20; B:0x30; C-F:0x00.
  - Reset takes priority over everything, including mid-instruction and while halted.
- Instruction format: IR[7:4]=opcode, IR[3:0]=address.
  - Opcodes: 0 LDA, 1 ADD, 2 SUB, E OUT, F HLT; all other opcodes are NOPs.
- Sequencer: T counts 0..5, then wraps to 0. One T-state per clock. Every instruction takes exactly 6 clocks.
- T0: MAR<=PC.
- T1: PC<=PC+1, wrapping mod 16.
- T2: IR<=RAM[MAR].
- T3:
  - LDA/ADD/SUB: MAR<=IR[3:0].
  - OUT: OUT<=A.
  - HLT: halted<=1.
- T4:
  - LDA: A<=RAM[MAR].
  - ADD/SUB: B<=RAM[MAR].
- T5:
  - ADD: A<=(A+B) mod 256.
  - SUB: A<=(A-B) mod 256, two's complement.
  - No carry or zero flags.
- Halt:
  - Once halted=1, T, PC and all registers freeze at their values after the HLT T3 edge.
  - uio_out[2:0] then reads 4 (T advanced past T3 on that edge). The freeze holds until reset.
- RAM is read combinationally (RAM[MAR]). There is no write path after reset.
- Outputs are purely registered; uo_out changes only on the OUT T3 edge.
- Timing: with edge 1 the first rising edge after rst deasserts, instruction k is in T-state j on edge 6k+j+1.

Decomposition:
- Package sap1_pkg:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - T-state count (6)
  - the 16-entry reset program image
- One natural sub-module, sap1_alu: combinational 8-bit add/sub with a sub select.
- Sequencer, datapath and RAM stay in the top module.

Test Plan:
- Reset check: hold rst=1 for 5 clocks -> uo_out=0x00; uio_out=0x00 (PC=0, halted=0, T=0); uio_oe=0xFF.
- Fetch timing: release rst -> after edge 2 PC=1 (uio_out[7:4]=1); after edge 3 IR=0x09; uio_out[2:0] steps 0..5 and wraps.
- Full program: run 40 clocks.
  - After edge 22 (OUT, T3) uo_out=0xE0. This exercises the 0xF0+0x20 add wrap to 0x10 and the 0x10-0x30 borrow wrap to 0xE0.
  - uo_out is 0x00 before edge 22.
- Halt: after edge 28, halted=1, PC=5, uio_out=0x5C. It stays constant for 50 further clocks while ui_in/uio_in are X.
- Reset mid-operation: assert rst at edge 15 (instruction 2, T2) -> all registers and outputs return to reset values; the program reruns and reproduces uo_out=0xE0 at edge 22 after release.
- Reset from halt: assert rst while halted -> halted=0, PC=0, and execution restarts.
